// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: glue between a UART receiver and a byte consumer.
// It owns the receiver's divider and parity settings and drives the receiver's
// edge-sensitive ack handshake. Received bytes go into a small FIFO that has a
// valid/ready output and a sticky overflow flag. The block watches the serial
// line for idle periods, and a new configuration is only applied while the line
// is idle, so the receiver settings never change in the middle of a frame.
// Optional build macro: UART_RX_CTRL_ACK_TIMEOUT_EN adds ack_timeout_o and caps
// the ack hold phase at 8 cycles.
module uart_rx_ctrl #(
  parameter int                             CLOCK_DIVIDER_WIDTH   = 16,
  parameter logic [CLOCK_DIVIDER_WIDTH-1:0] DEFAULT_CLOCK_DIVIDER = 16'd434,
  parameter int                             FIFO_DEPTH_LOG2       = 3,
  parameter int                             IDLE_BITS             = 10
) (
  input  logic                           clock_i,
  input  logic                           reset_n_i,
  input  logic                           serial_i,
  input  logic [7:0]                     rx_data_i,
  input  logic                           rx_ready_i,
  output logic                           rx_ack_o,
  output logic [CLOCK_DIVIDER_WIDTH-1:0] rx_clock_divider_o,
  output logic                           rx_parity_bit_o,
  output logic                           rx_parity_even_o,
  input  logic                           cfg_write_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] cfg_clock_divider_i,
  input  logic                           cfg_parity_bit_i,
  input  logic                           cfg_parity_even_i,
  output logic                           cfg_pending_o,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [FIFO_DEPTH_LOG2:0]       count_o,
  output logic                           overflow_o,
  output logic                           idle_o,
  input  logic                           clear_errors_i
`ifdef UART_RX_CTRL_ACK_TIMEOUT_EN
  ,
  output logic                           ack_timeout_o
`endif
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int IDLE_W = $clog2(IDLE_BITS + 1);
  localparam int CW     = CLOCK_DIVIDER_WIDTH;

  localparam logic [CNT_W-1:0]           FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);
  localparam logic [IDLE_W-1:0]          IDLE_MAX   = IDLE_W'(IDLE_BITS);
  localparam logic [IDLE_W-1:0]          IDLE_LAST  = IDLE_W'(IDLE_BITS - 1);
  localparam logic [IDLE_W-1:0]          IDLE_ONE   = IDLE_W'(1);

  typedef enum logic [1:0] {
    ACK_IDLE    = 2'd0,
    ACK_HOLD    = 2'd1,
    ACK_RELEASE = 2'd2
  } ack_state_t;

  ack_state_t state, state_nx;

  logic                       push;
  logic                       pop;
  logic                       full;
  logic                       push_ok;
  logic                       drop;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [7:0]                 mem [DEPTH];

  logic [CW-1:0]              cyc_cnt;
  logic [CW:0]                cyc_inc;
  logic                       wrap;
  logic [IDLE_W-1:0]          bit_cnt;
  logic                       line_idle;

  logic [CW-1:0]              pend_div;
  logic                       pend_parity_bit;
  logic                       pend_parity_even;
  logic                       apply;

`ifdef UART_RX_CTRL_ACK_TIMEOUT_EN
  logic [2:0]                 hold_cnt;
  logic                       timeout_hit;
`endif

  // Ack is high for exactly the hold phase; reset drops it immediately.
  assign rx_ack_o = (state == ACK_HOLD);

  // Ack handshake state register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= ACK_IDLE;
    else            state <= state_nx;
  end

  // Ack handshake next state: a byte is taken only from the idle state, so each
  // ready pulse from the receiver is pushed exactly once.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
`ifdef UART_RX_CTRL_ACK_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state)
      ACK_IDLE: begin
        if (rx_ready_i) begin
          push     = 1'b1;
          state_nx = ACK_HOLD;
        end
      end
      ACK_HOLD: begin
        if (!rx_ready_i) begin
          state_nx = ACK_RELEASE;
        end
`ifdef UART_RX_CTRL_ACK_TIMEOUT_EN
        else if (hold_cnt == 3'd7) begin
          state_nx    = ACK_RELEASE;
          timeout_hit = 1'b1;
        end
`endif
      end
      ACK_RELEASE: state_nx = ACK_IDLE;
      default:     state_nx = ACK_IDLE;
    endcase
  end

`ifdef UART_RX_CTRL_ACK_TIMEOUT_EN
  // Counts cycles spent in the hold phase with ready still high.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)              hold_cnt <= 3'd0;
    else if (state != ACK_HOLD)  hold_cnt <= 3'd0;
    else if (rx_ready_i)         hold_cnt <= hold_cnt + 3'd1;
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)          ack_timeout_o <= 1'b0;
    else if (timeout_hit)    ack_timeout_o <= 1'b1;
    else if (clear_errors_i) ack_timeout_o <= 1'b0;
  end
`endif

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign full    = (count == FULL_COUNT);
  assign pop     = valid_o && ready_i;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign valid_o = (count != '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];

  // FIFO storage; cleared on reset so data_o reads zero out of reset.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (push_ok) begin
      mem[wr_ptr] <= rx_data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the depth.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a dropped byte beats a simultaneous clear.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)          overflow_o <= 1'b0;
    else if (drop)           overflow_o <= 1'b1;
    else if (clear_errors_i) overflow_o <= 1'b0;
  end

  // The bit-period counter wraps after divider cycles. Dividers below 2 wrap
  // on every cycle.
  assign cyc_inc   = {1'b0, cyc_cnt} + {{CW{1'b0}}, 1'b1};
  assign wrap      = (cyc_inc >= {1'b0, rx_clock_divider_o});
  assign line_idle = (bit_cnt == IDLE_MAX);

  // Counts high bit periods on the line; any low sample restarts the count.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else if (!serial_i) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else if (wrap) begin
      cyc_cnt <= '0;
      if (bit_cnt != IDLE_MAX) bit_cnt <= bit_cnt + IDLE_ONE;
    end else begin
      cyc_cnt <= cyc_inc[CW-1:0];
    end
  end

  // One pulse when the bit count saturates; it cannot repeat until the line drops.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) idle_o <= 1'b0;
    else            idle_o <= serial_i && wrap && (bit_cnt == IDLE_LAST);
  end

  // A new configuration is committed only between frames with no handshake active.
  assign apply = cfg_pending_o && line_idle && (state == ACK_IDLE);

  // Pending configuration; the last write wins, and a write during the apply
  // cycle stays pending.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pend_div         <= '0;
      pend_parity_bit  <= 1'b0;
      pend_parity_even <= 1'b0;
      cfg_pending_o    <= 1'b0;
    end else begin
      if (cfg_write_i) begin
        pend_div         <= cfg_clock_divider_i;
        pend_parity_bit  <= cfg_parity_bit_i;
        pend_parity_even <= cfg_parity_even_i;
        cfg_pending_o    <= 1'b1;
      end else if (apply) begin
        cfg_pending_o    <= 1'b0;
      end
    end
  end

  // Receiver configuration; it changes only in an apply cycle.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_clock_divider_o <= DEFAULT_CLOCK_DIVIDER;
      rx_parity_bit_o    <= 1'b0;
      rx_parity_even_o   <= 1'b0;
    end else if (apply) begin
      rx_clock_divider_o <= pend_div;
      rx_parity_bit_o    <= pend_parity_bit;
      rx_parity_even_o   <= pend_parity_even;
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Controller between a UartRx instance and a byte consumer.
- Owns the receiver's configuration inputs (clock divider, parity) and its edge-sensitive ack handshake.
- Buffers received bytes in a small FIFO with a valid/ready output and reports overflow.
- Monitors the serial line for idle periods and applies new configuration only while the line is idle.

Parameters:
- CLOCK_DIVIDER_WIDTH, 16, width of all clock-divider values.
- DEFAULT_CLOCK_DIVIDER, 16'd434, divider driven to the receiver after reset.
- FIFO_DEPTH_LOG2, 3, FIFO holds 2**FIFO_DEPTH_LOG2 bytes (default 8).
- IDLE_BITS, 10, number of consecutive high bit periods that defines line idle.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- serial_i  in  1  serial line, monitored (same net as the receiver's serial input).
- rx_data_i  in  8  receiver data.
- rx_ready_i  in  1  receiver byte-ready.
- rx_ack_o  out  1  ack to receiver.
- rx_clock_divider_o  out  CLOCK_DIVIDER_WIDTH  divider to receiver.
- rx_parity_bit_o  out  1  parity enable to receiver.
- rx_parity_even_o  out  1  parity even/odd to receiver.
- cfg_write_i  in  1  one-cycle strobe; latch cfg_* into the pending register.
- cfg_clock_divider_i  in  CLOCK_DIVIDER_WIDTH  requested divider.
- cfg_parity_bit_i  in  1  requested parity enable.
- cfg_parity_even_i  in  1  requested parity sense.
- cfg_pending_o  out  1  a configuration is latched but not yet applied.
- data_o  out  8  FIFO head byte.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o when valid_o is high.
- count_o  out  FIFO_DEPTH_LOG2+1  FIFO occupancy.
- overflow_o  out  1  sticky; a byte was dropped.
- idle_o  out  1  one-cycle pulse when the line becomes idle.
- clear_errors_i  in  1  clears overflow_o and ack_timeout_o.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - All outputs are 0, except rx_clock_divider_o = DEFAULT_CLOCK_DIVIDER.
  - FIFO is emptied, FSM goes to ACK_IDLE, idle counters are zeroed, pending configuration is cleared.
- Ack FSM, states ACK_IDLE, ACK_HOLD, ACK_RELEASE:
  - ACK_IDLE: when rx_ready_i = 1, push rx_data_i into the FIFO, drive rx_ack_o = 1, go to ACK_HOLD.
  - ACK_HOLD: rx_ack_o stays 1 until rx_ready_i = 0, then go to ACK_RELEASE.
  - ACK_RELEASE: rx_ack_o = 0 for exactly one cycle (this re-arms the receiver's ack edge detector), then go to ACK_IDLE.
  - Any rx_ready_i outside ACK_IDLE is ignored. Each byte is pushed exactly once.
- FIFO:
  - Pop occurs when valid_o && ready_i. data_o is the registered head; a pushed byte is first visible the cycle after the push.
  - Push while full without a simultaneous pop: the byte is dropped but still acked, and overflow_o is set.
  - Push while full with a simultaneous pop: both succeed and count is unchanged.
  - Pointers wrap modulo depth. count_o ranges 0..2**FIFO_DEPTH_LOG2.
- Idle detection:
  - A cycle counter runs 0..rx_clock_divider_o-1. A bit counter (saturating at IDLE_BITS) increments on each counter wrap while serial_i = 1.
  - serial_i = 0 zeroes both counters.
  - idle_o pulses for one cycle when the bit counter reaches IDLE_BITS; it pulses once per high stretch.
  - line_idle = (bit counter == IDLE_BITS).
- Configuration:
  - cfg_write_i latches the pending register and sets cfg_pending_o. A later write overwrites an earlier one (last write wins).
  - The pending configuration is applied to the rx_* outputs on the first cycle where line_idle = 1 and the FSM is in ACK_IDLE. cfg_pending_o clears in that same cycle.
  - cfg_write_i in the apply cycle: the new value stays pending and is applied on the next eligible cycle.
  - rx_* outputs never change otherwise, so they are never altered mid-frame.
  - A divider value below 2 is still applied as written; the receiver treats it as disabled.
- clear_errors_i and a new overflow in the same cycle: set wins.
- Reset mid-handshake: rx_ack_o drops asynchronously and the byte is lost.

Optional Feature:
- Macro UART_RX_CTRL_ACK_TIMEOUT_EN.
- When defined:
  - Adds output ack_timeout_o (1 bit, sticky, cleared by clear_errors_i, reset 0).
  - If ACK_HOLD lasts 8 cycles without rx_ready_i falling, the FSM forces ACK_RELEASE and sets ack_timeout_o.
- When undefined:
  - ACK_HOLD waits indefinitely.
  - The ack_timeout_o port does not exist.

Test Plan:
- Reset release, serial_i high, no cfg write -> rx_clock_divider_o = 434; idle_o pulses once, 4340 cycles after the reset release; valid_o = 0.
- Receiver emulator presents 0xA5, ready drops 1 cycle after ack -> one push; rx_ack_o high 2 cycles, then low 1 cycle; data_o = 0xA5, valid_o = 1, count_o = 1.
- 9 bytes 0x01..0x09 with ready_i = 0 -> count_o = 8, overflow_o = 1, all 9 acked, pops return 0x01..0x08; clear_errors_i clears overflow_o.
- Full FIFO, push and pop in the same cycle -> count_o stays 8, no overflow, new byte appears last.
- cfg_write_i (divider 16, parity even) while serial_i toggling -> cfg_pending_o = 1, rx_* unchanged; after 10 high bit periods (4340 cycles at the old divider) outputs update and cfg_pending_o = 0.
- With UART_RX_CTRL_ACK_TIMEOUT_EN, rx_ready_i held high -> rx_ack_o falls after 8 cycles, ack_timeout_o = 1.
